mmm_ctrl: RTL and testbench
===========================

MMM_CTRL -- requirements
Module: mmm_ctrl

Interface
REQ-001 Parameter WIDTH, default 10: operand, modulus and result width in bits; also the number of RUN cycles.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  operation request, sampled only while ready=1.
REQ-005 op_a  input  WIDTH  multiplicand A.
REQ-006 op_b  input  WIDTH  multiplier B.
REQ-007 op_m  input  WIDTH  modulus M.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 done  output  1  single-cycle pulse; result and err valid while high.
REQ-010 err  output  1  operand-check failure flag, valid with done.
REQ-011 result  output  WIDTH  fully reduced product A*B*2^-WIDTH mod M.
REQ-012 mmm_en  output  1  enable to the multiplier datapath.
REQ-013 mmm_rst_n  output  1  active-low clear to the multiplier datapath.
REQ-014 mmm_ld_a  output  1  operand-load strobe.
REQ-015 mmm_ld_r  output  1  result-capture strobe.
REQ-016 mmm_lock  output  1  result-register hold; low only while capturing.
REQ-017 mmm_a, mmm_b, mmm_m  output  WIDTH each  latched operands driven to the multiplier.
REQ-018 mmm_r  input  WIDTH  raw multiplier result, below 2M.

Function
REQ-019 States SHALL be IDLE, CLR, LOAD, RUN, CAPTURE, REDUCE, DONE.
REQ-020 In IDLE with start=1, the controller SHALL latch op_a, op_b and op_m into internal registers on that edge.
REQ-021 Operand check at that edge: the check SHALL fail if op_m[0]=0, op_m[WIDTH-1]=1, op_a>=op_m or op_b>=op_m.
REQ-022 On a failed check, the next state SHALL be DONE with err=1 and result=0; otherwise the next state SHALL be CLR with err=0.
REQ-023 CLR SHALL last 1 cycle, with mmm_rst_n=0 and mmm_en=0.
REQ-024 LOAD SHALL last 1 cycle, with mmm_en=1 and mmm_ld_a=1.
REQ-025 RUN SHALL last exactly WIDTH cycles, with mmm_en=1, counted by a down-counter loaded with WIDTH-1 on LOAD exit that leaves RUN at 0.
REQ-026 CAPTURE SHALL last 1 cycle, with mmm_en=1, mmm_ld_r=1 and mmm_lock=0.
REQ-027 REDUCE SHALL last 1 cycle and register result = (mmm_r >= mmm_m) ? mmm_r - mmm_m : mmm_r, subtraction WIDTH bits wide with no borrow out.
REQ-028 DONE SHALL last 1 cycle with done=1, then return to IDLE; result and err SHALL hold until the next accepted start.
REQ-029 Default strobe levels in all states: mmm_rst_n=1, mmm_lock=1, mmm_en=0, mmm_ld_a=0, mmm_ld_r=0, except as stated above.
REQ-030 mmm_a, mmm_b and mmm_m SHALL equal the latched operands and stay stable from CLR through DONE.
REQ-031 Latency: done SHALL assert exactly WIDTH+5 edges after the edge that accepted start (15 at WIDTH=10), or 1 edge after it on a check failure.
REQ-032 start outside IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-033 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 rst=1 SHALL force IDLE at the next edge from any state, overriding start.
REQ-036 Reset values: ready=1, done=0, err=0, result=0, mmm_rst_n=1, mmm_en=0, mmm_ld_a=0, mmm_ld_r=0, mmm_lock=1, mmm_a=mmm_b=mmm_m=0, counter=0.
REQ-037 Reset mid-operation SHALL abort the operation without a done pulse.

Verification
REQ-038 Bench SHALL model the multiplier behaviourally, returning A*B*2^-WIDTH mod M on the capture edge, optionally plus M.
REQ-039 Normal operation: A=5, B=7, M=13, start for 1 cycle -> done exactly 15 edges later; result=10, err=0; mmm_en high for exactly 12 cycles.
REQ-040 Final reduction: model forced to return mmm_r=16 with M=13 -> result=3; model returning 10 -> result=10.
REQ-041 Operand errors: M=12 -> done 1 edge after start, err=1, result=0, mmm_en never high; A=13 with M=13 -> same response.
REQ-042 start pulsed during RUN -> ignored, a single done; start held high -> back-to-back operations, ready high for exactly 1 cycle between them.
REQ-043 rst asserted in RUN cycle 4 -> IDLE on the next edge, all reset values per REQ-036, no done pulse; a new start afterwards completes normally with A=1, B=1, M=13 -> result=4.

Source files
------------

// File: rtl/mmm_ctrl_if.sv
// Bundle of the start/result handshake and the strobes/operands exchanged
// with the Montgomery multiplier datapath.
interface mmm_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_m;
    logic             ready;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic             mmm_en;
    logic             mmm_rst_n;
    logic             mmm_ld_a;
    logic             mmm_ld_r;
    logic             mmm_lock;
    logic [WIDTH-1:0] mmm_a;
    logic [WIDTH-1:0] mmm_b;
    logic [WIDTH-1:0] mmm_m;
    logic [WIDTH-1:0] mmm_r;

    modport slave (
        input  start, op_a, op_b, op_m, mmm_r,
        output ready, done, err, result,
        output mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock,
        output mmm_a, mmm_b, mmm_m
    );

    modport master (
        output start, op_a, op_b, op_m, mmm_r,
        input  ready, done, err, result,
        input  mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock,
        input  mmm_a, mmm_b, mmm_m
    );
endinterface

// File: rtl/mmm_ctrl.sv
// Sequencer for a bit-serial Montgomery multiplier: operand check, datapath
// strobes, WIDTH-cycle run and the final conditional subtraction.
module mmm_ctrl #(
    parameter int WIDTH = 10
) (
    input logic       clk,
    input logic       rst,
    mmm_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_REDUCE,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             ready_reg;
    logic             done_reg;
    logic             err_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic             en_reg;
    logic             rst_n_reg;
    logic             ld_a_reg;
    logic             ld_r_reg;
    logic             lock_reg;

    logic             op_bad;
    logic             r_ge_m;
    logic [WIDTH-1:0] r_minus_m;

    // Montgomery needs an odd modulus below 2^(WIDTH-1) and reduced operands.
    assign op_bad = !bus.op_m[0] || bus.op_m[WIDTH-1] ||
                    (bus.op_a >= bus.op_m) || (bus.op_b >= bus.op_m);

    // Raw product is below 2M, so one conditional subtraction fully reduces it.
    assign r_ge_m    = (bus.mmm_r >= m_reg);
    assign r_minus_m = bus.mmm_r - m_reg;

    // Every output is a register loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            result_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            en_reg     <= 1'b0;
            rst_n_reg  <= 1'b1;
            ld_a_reg   <= 1'b0;
            ld_r_reg   <= 1'b0;
            lock_reg   <= 1'b1;
        end else begin
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            en_reg    <= 1'b0;
            rst_n_reg <= 1'b1;
            ld_a_reg  <= 1'b0;
            ld_r_reg  <= 1'b0;
            lock_reg  <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    ready_reg <= 1'b1;
                    if (bus.start) begin
                        ready_reg <= 1'b0;
                        a_reg     <= bus.op_a;
                        b_reg     <= bus.op_b;
                        m_reg     <= bus.op_m;
                        if (op_bad) begin
                            state_reg  <= S_DONE;
                            done_reg   <= 1'b1;
                            err_reg    <= 1'b1;
                            result_reg <= '0;
                        end else begin
                            state_reg <= S_CLR;
                            err_reg   <= 1'b0;
                            rst_n_reg <= 1'b0;
                        end
                    end
                end

                S_CLR: begin
                    state_reg <= S_LOAD;
                    en_reg    <= 1'b1;
                    ld_a_reg  <= 1'b1;
                end

                S_LOAD: begin
                    state_reg <= S_RUN;
                    cnt_reg   <= RUN_LAST;
                    en_reg    <= 1'b1;
                end

                S_RUN: begin
                    en_reg <= 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= S_CAPTURE;
                        ld_r_reg  <= 1'b1;
                        lock_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                S_CAPTURE: begin
                    state_reg <= S_REDUCE;
                end

                S_REDUCE: begin
                    state_reg  <= S_DONE;
                    done_reg   <= 1'b1;
                    result_reg <= r_ge_m ? r_minus_m : bus.mmm_r;
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = ready_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.result    = result_reg;
    assign bus.mmm_en    = en_reg;
    assign bus.mmm_rst_n = rst_n_reg;
    assign bus.mmm_ld_a  = ld_a_reg;
    assign bus.mmm_ld_r  = ld_r_reg;
    assign bus.mmm_lock  = lock_reg;
    assign bus.mmm_a     = a_reg;
    assign bus.mmm_b     = b_reg;
    assign bus.mmm_m     = m_reg;
endmodule

// File: tb/tb_mmm_ctrl.sv
// Scoreboarded bench for mmm_ctrl with a behavioural Montgomery multiplier
// model and randomized plus directed operations.
module tb_mmm_ctrl;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmm_ctrl_if #(.WIDTH(W)) bus ();
    mmm_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int a;
        int b;
        int m;
        int err;
        int res;
        int lat;
        int en_cycles;
        int ld_a_cycles;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   ld_a_cnt = 0;
    int   force_val = -1;
    bit   add_m = 1'b0;
    int   model_v;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // A*B*2^-W mod M found by searching for r with r*2^W == A*B (mod M).
    function automatic int mont(input int a, input int b, input int m);
        int t;
        int rw;
        if (m <= 0) return 0;
        t  = (a * b) % m;
        rw = (1 << W) % m;
        for (int r = 0; r < m; r++)
            if ((r * rw) % m == t) return r;
        return 0;
    endfunction

    function automatic bit operands_bad(input int a, input int b, input int m);
        return (m % 2 == 0) || (m >= (1 << (W - 1))) || (a >= m) || (b >= m);
    endfunction

    // Multiplier datapath model: scrambles on clear, presents its product on the capture edge.
    always @(negedge clk) begin
        if (!bus.mmm_rst_n) bus.mmm_r = W'($urandom);
        if (bus.mmm_ld_r) begin
            if (force_val >= 0) model_v = force_val;
            else begin
                model_v = mont(int'(bus.mmm_a), int'(bus.mmm_b), int'(bus.mmm_m));
                if (add_m) model_v += int'(bus.mmm_m);
            end
            @(posedge clk);
            #1 bus.mmm_r = W'(model_v);
        end
    end

    // Scoreboard: push on each accepted start, pop and compare on each done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            en_cnt   = 0;
            ld_a_cnt = 0;
        end else begin
            if (bus.mmm_en) en_cnt++;
            if (bus.mmm_ld_a) ld_a_cnt++;
            check("lock_vs_capture", int'(bus.mmm_lock), int'(!bus.mmm_ld_r));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err", int'(bus.err), e.err);
                    check("result", int'(bus.result), e.res);
                    check("latency", cyc + 1 - e.acc, e.lat);
                    check("en_cycles", en_cnt, e.en_cycles);
                    check("ld_a_cycles", ld_a_cnt, e.ld_a_cycles);
                    check("mmm_a", int'(bus.mmm_a), e.a);
                    check("mmm_b", int'(bus.mmm_b), e.b);
                    check("mmm_m", int'(bus.mmm_m), e.m);
                    $display("op a=%0d b=%0d m=%0d -> err=%0d result=%0d (expected err=%0d result=%0d)",
                             e.a, e.b, e.m, bus.err, bus.result, e.err, e.res);
                end
            end
            if (bus.start && bus.ready) begin
                e.a   = int'(bus.op_a);
                e.b   = int'(bus.op_b);
                e.m   = int'(bus.op_m);
                e.acc = cyc + 1;
                if (operands_bad(e.a, e.b, e.m)) begin
                    e.err = 1; e.res = 0; e.lat = 1; e.en_cycles = 0; e.ld_a_cycles = 0;
                end else begin
                    e.err = 0; e.lat = W + 5; e.en_cycles = W + 2; e.ld_a_cycles = 1;
                    if (force_val >= 0) e.res = (force_val >= e.m) ? force_val - e.m : force_val;
                    else e.res = mont(e.a, e.b, e.m);
                end
                exp_q.push_back(e);
                en_cnt   = 0;
                ld_a_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.ready) check("ready_timeout", 0, 1);
    endtask

    task automatic issue(input int a, input int b, input int m);
        wait_ready();
        bus.op_a  = W'(a);
        bus.op_b  = W'(b);
        bus.op_m  = W'(m);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check("rst_ready", int'(bus.ready), 1);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_mmm_rst_n", int'(bus.mmm_rst_n), 1);
        check("rst_mmm_en", int'(bus.mmm_en), 0);
        check("rst_mmm_ld_a", int'(bus.mmm_ld_a), 0);
        check("rst_mmm_ld_r", int'(bus.mmm_ld_r), 0);
        check("rst_mmm_lock", int'(bus.mmm_lock), 1);
        check("rst_mmm_abm", int'(bus.mmm_a | bus.mmm_b | bus.mmm_m), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.op_m  = '0;
        bus.mmm_r = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values();

        // Normal operation and forced final-reduction cases.
        issue(5, 7, 13);   wait_done();
        force_val = 16; issue(2, 3, 13); wait_done();
        force_val = 10; issue(2, 3, 13); wait_done();
        force_val = -1;

        // Operand-check failures.
        issue(3, 4, 12);   wait_done();
        issue(13, 1, 13);  wait_done();
        issue(1, 1, 515);  wait_done();

        // start pulsed during RUN must be ignored.
        issue(9, 11, 23);
        repeat (5) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;

        // start held high: back-to-back operations with one ready cycle between.
        bus.op_a = W'(17); bus.op_b = W'(30); bus.op_m = W'(31);
        bus.start = 1'b1;
        wait_done();
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (!bus.ready) break;
            n++;
        end
        bus.start = 1'b0;
        check("b2b_ready_cycles", n, 1);
        wait_done();

        // Reset during RUN cycle 4 aborts without done.
        issue(100, 200, 251);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset_values();
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check("abort_done_count", n, 0);
        @(posedge clk); #1;
        issue(1, 1, 13);   wait_done();

        // Randomized operations, occasionally invalid, sometimes with a raw result >= M.
        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(3, 511) | 1;
            if ($urandom_range(0, 7) == 0) m = $urandom_range(2, 1023);
            add_m = 1'($urandom_range(0, 1));
            issue($urandom_range(0, m - 1), $urandom_range(0, m - 1 + ($urandom_range(0, 9) == 0 ? 3 : 0)), m);
            wait_done();
        end
        add_m = 1'b0;

        repeat (5) @(posedge clk);
        check("pending_ops", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
